// File: rtl/player_missile.sv
// Single-missile controller: launches from the ship's nose on a fire-key press edge,
// climbs a fixed step per frame, and retires on a hit or at the top of the screen.
module player_missile #(
    parameter logic [9:0] MISSILE_STEP    = 10'd4,
    parameter logic [9:0] MISSILE_LEN     = 10'd8,
    parameter logic [9:0] MISSILE_Y_MIN   = 10'd0,
    parameter logic [3:0] COOLDOWN_FRAMES = 4'd8,
    parameter logic [7:0] FIRE_KEY        = 8'h2C
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic [7:0] keycode,
    input  logic [9:0] PlayerX,
    input  logic [9:0] PlayerY,
    input  logic       hit,
    output logic [9:0] MissileX,
    output logic [9:0] MissileY,
    output logic       MissileActive,
    output logic       fire_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLIGHT,
        ST_COOLDOWN
    } state_t;

    state_t     r_state;
    logic       r_key_prev;
    logic [3:0] r_cool_cnt;

    logic       w_fire_key;
    logic       w_press;
    logic       w_off_screen;
    logic [9:0] w_spawn_y;

    assign w_fire_key   = (keycode == FIRE_KEY);
    assign w_press      = w_fire_key && !r_key_prev;
    assign w_off_screen = (MissileY < (MISSILE_Y_MIN + MISSILE_STEP));
    // Spawning just above a ship near the top clamps to row 0 instead of wrapping.
    assign w_spawn_y    = (PlayerY >= MISSILE_LEN) ? (PlayerY - MISSILE_LEN) : 10'd0;

    // NOTE: all state updates use non-blocking assignments so every register samples
    // the values from before this edge, regardless of statement order.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state       <= ST_IDLE;
            r_key_prev    <= 1'b1;
            r_cool_cnt    <= 4'd0;
            MissileX      <= 10'd0;
            MissileY      <= 10'd0;
            MissileActive <= 1'b0;
            fire_pulse    <= 1'b0;
        end else begin
            r_key_prev <= w_fire_key;
            fire_pulse <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_press) begin
                        r_state       <= ST_FLIGHT;
                        MissileX      <= PlayerX;
                        MissileY      <= w_spawn_y;
                        MissileActive <= 1'b1;
                        fire_pulse    <= 1'b1;
                    end
                end

                ST_FLIGHT: begin
                    // A hit wins over leaving the screen; both retire the same way.
                    if (hit || w_off_screen) begin
                        r_state       <= ST_COOLDOWN;
                        r_cool_cnt    <= COOLDOWN_FRAMES - 4'd1;
                        MissileActive <= 1'b0;
                    end else begin
                        MissileY <= MissileY - MISSILE_STEP;
                    end
                end

                ST_COOLDOWN: begin
                    if (r_cool_cnt == 4'd0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cool_cnt <= r_cool_cnt - 4'd1;
                    end
                end

                default: begin
                    r_state       <= ST_IDLE;
                    MissileActive <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_missile.sv
// Directed bench for player_missile: a vector table for launch/steering, then
// hand-written sequences for full flight, cooldown, hit, async reset and spawn clamp.
module tb_player_missile;

    logic       frame_clk = 1'b0;
    logic       Reset_n;
    logic [7:0] keycode;
    logic [9:0] PlayerX;
    logic [9:0] PlayerY;
    logic       hit;
    logic [9:0] MissileX;
    logic [9:0] MissileY;
    logic       MissileActive;
    logic       fire_pulse;

    int checks   = 0;
    int failures = 0;

    player_missile dut (
        .frame_clk    (frame_clk),
        .Reset_n      (Reset_n),
        .keycode      (keycode),
        .PlayerX      (PlayerX),
        .PlayerY      (PlayerY),
        .hit          (hit),
        .MissileX     (MissileX),
        .MissileY     (MissileY),
        .MissileActive(MissileActive),
        .fire_pulse   (fire_pulse)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        logic [7:0] key;
        logic [9:0] px;
        logic [9:0] py;
        logic       hit;
        logic       act;
        logic       fire;
        logic [9:0] x;
        logic [9:0] y;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic act, input logic fire,
                              input logic [9:0] x, input logic [9:0] y);
        check({tag, "_active"}, 32'(MissileActive), 32'(act));
        check({tag, "_fire"},   32'(fire_pulse),    32'(fire));
        check({tag, "_x"},      32'(MissileX),      32'(x));
        check({tag, "_y"},      32'(MissileY),      32'(y));
    endtask

    initial begin
        // Launch at table row 2 (edge k) with PlayerX=320, PlayerY=420; X then frozen.
        vecs[0] = '{8'h2C, 10'd320, 10'd420, 1'b0, 1'b0, 1'b0, 10'd0,   10'd0};
        vecs[1] = '{8'h00, 10'd320, 10'd420, 1'b0, 1'b0, 1'b0, 10'd0,   10'd0};
        vecs[2] = '{8'h2C, 10'd320, 10'd420, 1'b0, 1'b1, 1'b1, 10'd320, 10'd412};
        vecs[3] = '{8'h2C, 10'd320, 10'd420, 1'b0, 1'b1, 1'b0, 10'd320, 10'd408};
        vecs[4] = '{8'h00, 10'd100, 10'd420, 1'b0, 1'b1, 1'b0, 10'd320, 10'd404};
        vecs[5] = '{8'h2C, 10'd100, 10'd420, 1'b0, 1'b1, 1'b0, 10'd320, 10'd400};
        vecs[6] = '{8'h00, 10'd100, 10'd420, 1'b0, 1'b1, 1'b0, 10'd320, 10'd396};

        // Fire key held through reset must not launch.
        Reset_n = 1'b0;
        keycode = 8'h2C;
        PlayerX = 10'd320;
        PlayerY = 10'd420;
        hit     = 1'b0;
        #12;
        check_outs("reset", 1'b0, 1'b0, 10'd0, 10'd0);
        tick();
        Reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            keycode = vecs[i].key;
            PlayerX = vecs[i].px;
            PlayerY = vecs[i].py;
            hit     = vecs[i].hit;
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].act, vecs[i].fire, vecs[i].x, vecs[i].y);
        end

        // Remaining flight k+5..k+103 with stray presses that must be discarded.
        for (int n = 5; n <= 103; n++) begin
            keycode = (n % 2 == 1) ? 8'h2C : 8'h00;
            tick();
            check_outs($sformatf("flight_k%0d", n), 1'b1, 1'b0, 10'd320, 10'(412 - 4 * n));
        end
        keycode = 8'h00;
        tick();
        check_outs("retire_k104", 1'b0, 1'b0, 10'd320, 10'd0);

        for (int n = 105; n <= 112; n++) begin
            keycode = (n % 2 == 1) ? 8'h2C : 8'h00;
            tick();
            check_outs($sformatf("cool_k%0d", n), 1'b0, 1'b0, 10'd320, 10'd0);
        end
        keycode = 8'h2C;
        tick();
        check_outs("relaunch_k113", 1'b1, 1'b1, 10'd100, 10'd412);

        // Hit mid-flight: hit sampled while Y shows 372; Y must not advance.
        keycode = 8'h00;
        PlayerX = 10'd200;
        for (int n = 1; n <= 10; n++) tick();
        check_outs("pre_hit", 1'b1, 1'b0, 10'd100, 10'd372);
        hit = 1'b1;
        tick();
        hit = 1'b0;
        check_outs("hit_m", 1'b0, 1'b0, 10'd100, 10'd372);
        for (int n = 1; n <= 8; n++) begin
            tick();
            check_outs($sformatf("hit_cool_m%0d", n), 1'b0, 1'b0, 10'd100, 10'd372);
        end
        keycode = 8'h2C;
        tick();
        check_outs("hit_relaunch_m9", 1'b1, 1'b1, 10'd200, 10'd412);

        // Async reset between edges clears outputs without a clock.
        keycode = 8'h00;
        tick();
        tick();
        check_outs("pre_areset", 1'b1, 1'b0, 10'd200, 10'd404);
        #2;
        Reset_n = 1'b0;
        #1;
        check_outs("areset", 1'b0, 1'b0, 10'd0, 10'd0);
        #3;
        Reset_n = 1'b1;
        tick();
        check_outs("post_areset", 1'b0, 1'b0, 10'd0, 10'd0);

        // Spawn clamp at PlayerY=5; retire next edge with simultaneous hit.
        keycode = 8'h2C;
        PlayerX = 10'd50;
        PlayerY = 10'd5;
        tick();
        check_outs("sat_launch", 1'b1, 1'b1, 10'd50, 10'd0);
        keycode = 8'h00;
        hit     = 1'b1;
        tick();
        hit     = 1'b0;
        check_outs("sat_retire", 1'b0, 1'b0, 10'd50, 10'd0);
        for (int n = 1; n <= 8; n++) tick();
        check_outs("sat_cool_end", 1'b0, 1'b0, 10'd50, 10'd0);
        keycode = 8'h2C;
        PlayerY = 10'd8;
        tick();
        check_outs("len_edge_launch", 1'b1, 1'b1, 10'd50, 10'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
